// File: rtl/riscv_pkg.sv
`timescale 1ps/1ps
// Shared types and encodings for the multicycle RV32I-subset control unit:
// FSM states, opcodes, datapath select codes and the per-state control word.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       trap;
    logic       done;
  } ctrl_t;

  // Moore control word for each state; anything not set stays 0.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.pc_update  = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
        c.done       = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
        c.done      = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_RD2;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
        c.done       = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = SRCA_RD1;
        c.alu_src_b  = SRCB_RD2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.branch     = 1'b1;
        c.done       = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALUOUT;
        c.pc_update  = 1'b1;
      end
      S_TRAP:  c.trap = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/riscv_alu_dec.sv
`timescale 1ps/1ps
// ALU decoder: maps the FSM's ALUOp plus instruction fields to ALUControl.
module riscv_alu_dec
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op[5]=1) can encode sub; addi ignores instr[30].
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
`timescale 1ps/1ps
// Main control for the multicycle RV32I-subset core: Moore FSM with a
// registered control word, inline ImmSrc decode and a retired counter.
module riscv_multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int CNT_W           = 32,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       ImmSrc,
  output logic             RegWrite,
  output logic             trap,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;
  logic   legal_op;
  logic   skip_illegal;

  always_comb begin
    legal_op = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
    skip_illegal = (state == S_DECODE) && !legal_op && (TRAP_ON_ILLEGAL == 0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECUTER;
          OP_I:         state_nxt = S_EXECUTEI;
          OP_JAL:       state_nxt = S_JAL;
          OP_BEQ:       state_nxt = S_BEQ;
          default:      state_nxt = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_nxt = S_MEMWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = S_FETCH;
      S_EXECUTER: state_nxt = S_ALUWB;
      S_EXECUTEI: state_nxt = S_ALUWB;
      S_JAL:      state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BEQ:      state_nxt = S_FETCH;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Control word is registered alongside the state so it always equals
  // state_ctrl(state), including the FETCH word held during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      ctrl    <= state_ctrl(S_FETCH);
      retired <= '0;
    end else begin
      state <= state_nxt;
      ctrl  <= state_ctrl(state_nxt);
      if (instr_done) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  riscv_alu_dec u_alu_dec (
    .alu_op      (ctrl.alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

  assign PCWrite    = ctrl.pc_update | (ctrl.branch & Zero);
  assign AdrSrc     = ctrl.adr_src;
  assign MemWrite   = ctrl.mem_write;
  assign IRWrite    = ctrl.ir_write;
  assign ResultSrc  = ctrl.result_src;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign RegWrite   = ctrl.reg_write;
  assign trap       = ctrl.trap;
  assign instr_done = ctrl.done | skip_illegal;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
`timescale 1ps/1ps
// Scoreboard bench for riscv_multicycle_ctrl: an instruction-level model
// queues the expected control word per cycle and the retirement events.
module tb_riscv_multicycle_ctrl;

  localparam int CNT_W = 32;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_BEQ = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [2:0] A_ADD = 3'b000;
  localparam logic [2:0] A_SUB = 3'b001;

  logic             clk = 1'b0;
  logic             reset;
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             Zero;
  logic             PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, trap, instr_done;
  logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]       ALUControl;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  riscv_multicycle_ctrl #(.CNT_W(CNT_W), .TRAP_ON_ILLEGAL(1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .trap(trap), .instr_done(instr_done), .retired(retired)
  );

  typedef struct packed {
    logic        pcw, adr, mw, irw;
    logic [1:0]  rs, sa, sb;
    logic [2:0]  ac;
    logic [1:0]  imm;
    logic        rw, trp, dn;
    logic [31:0] ret;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] done_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] model_ret = '0;
  logic [1:0]  cur_imm;
  int          push_cnt, push_lim;

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == T_SW)  return 2'b01;
    if (o == T_BEQ) return 2'b10;
    if (o == T_JAL) return 2'b11;
    return 2'b00;
  endfunction

  // Operation the instruction's funct fields ask the ALU for.
  function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    if (f3 == 3'b000 && o == T_R && f7) return A_SUB;
    return A_ADD;
  endfunction

  function automatic exp_t mk(input logic pcw, adr, mw, irw, input logic [1:0] rs, sa, sb,
                              input logic [2:0] ac, input logic rw, trp, dn);
    exp_t e;
    e = '0;
    e.pcw = pcw; e.adr = adr; e.mw = mw; e.irw = irw;
    e.rs = rs; e.sa = sa; e.sb = sb; e.ac = ac;
    e.rw = rw; e.trp = trp; e.dn = dn;
    return e;
  endfunction

  task automatic push(input exp_t e);
    exp_t x;
    x = e;
    if (push_cnt < push_lim) begin
      x.imm = cur_imm;
      x.ret = model_ret;
      exp_q.push_back(x);
      if (x.dn) begin
        done_q.push_back(model_ret);
        model_ret = model_ret + 32'd1;
      end
      push_cnt++;
    end
  endtask

  // Expected per-cycle behaviour of one instruction, truncated to lim cycles.
  task automatic expect_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                              input logic z, input int lim, output int n);
    push_cnt = 0;
    push_lim = lim;
    cur_imm  = imm_of(o);
    push(mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, A_ADD, 0, 0, 0));
    push(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, A_ADD, 0, 0, 0));
    if (o == T_LW || o == T_SW) begin
      push(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, A_ADD, 0, 0, 0));
      if (o == T_LW) begin
        push(mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, A_ADD, 0, 0, 0));
        push(mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, A_ADD, 1, 0, 1));
      end else begin
        push(mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, A_ADD, 0, 0, 1));
      end
    end else if (o == T_R || o == T_I || o == T_JAL) begin
      if (o == T_R)   push(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu_of(o, f3, f7), 0, 0, 0));
      if (o == T_I)   push(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu_of(o, f3, f7), 0, 0, 0));
      if (o == T_JAL) push(mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, A_ADD, 0, 0, 0));
      push(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, A_ADD, 1, 0, 1));
    end else if (o == T_BEQ) begin
      push(mk(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, A_SUB, 0, 0, 1));
    end else begin
      for (int k = 0; k < 20; k++) push(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, A_ADD, 0, 1, 0));
    end
    n = push_cnt;
  endtask

  task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    int n;
    drive(o, f3, f7, z);
    expect_instr(o, f3, f7, z, 100, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset; the cycle sampled under reset doubles as the FETCH of the next op.
  task automatic reset_into(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    int n;
    reset = 1'b1;
    model_ret = '0;
    drive(o, f3, f7, z);
    expect_instr(o, f3, f7, z, 100, n);
    @(negedge clk);
    #2;
    reset = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: one expected control word per cycle, retirement on instr_done.
  initial begin
    exp_t e, a;
    logic [31:0] r;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '0;
        a.pcw = PCWrite; a.adr = AdrSrc; a.mw = MemWrite; a.irw = IRWrite;
        a.rs = ResultSrc; a.sa = ALUSrcA; a.sb = ALUSrcB; a.ac = ALUControl;
        a.imm = ImmSrc; a.rw = RegWrite; a.trp = trap; a.dn = instr_done; a.ret = retired;
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL ctrl cyc=%0d op=%b actual pcw%b adr%b mw%b irw%b rs%b sa%b sb%b ac%b imm%b rw%b trap%b done%b ret%0d required pcw%b adr%b mw%b irw%b rs%b sa%b sb%b ac%b imm%b rw%b trap%b done%b ret%0d",
                   cyc, op, a.pcw, a.adr, a.mw, a.irw, a.rs, a.sa, a.sb, a.ac, a.imm, a.rw, a.trp, a.dn, a.ret,
                   e.pcw, e.adr, e.mw, e.irw, e.rs, e.sa, e.sb, e.ac, e.imm, e.rw, e.trp, e.dn, e.ret);
        end
      end
      if (instr_done === 1'b1) begin
        n_checks++;
        if (done_q.size() == 0) begin
          n_fail++;
          $display("FAIL retire_event cyc=%0d actual unexpected instr_done retired=%0d required no retirement", cyc, retired);
        end else begin
          r = done_q.pop_front();
          if (retired !== r) begin
            n_fail++;
            $display("FAIL retire_count cyc=%0d actual %0d required %0d", cyc, retired, r);
          end
        end
      end
    end
  end

  initial begin
    logic [6:0] legal_ops [6];
    int n;
    int wait_cyc;
    legal_ops = '{T_LW, T_SW, T_R, T_I, T_BEQ, T_JAL};
    reset = 1'b1;
    drive(T_LW, 3'b010, 1'b0, 1'b0);
    push_cnt = 0;
    push_lim = 1;
    cur_imm  = imm_of(T_LW);
    push(mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, A_ADD, 0, 0, 0));
    @(negedge clk);
    #1;
    reset_into(T_LW, 3'b010, 1'b0, 1'b0);

    run_instr(T_SW, 3'b010, 1'b0, 1'b1);
    run_instr(T_R, 3'b000, 1'b1, 1'b0);
    run_instr(T_R, 3'b111, 1'b0, 1'b0);
    run_instr(T_I, 3'b010, 1'b1, 1'b0);
    run_instr(T_BEQ, 3'b000, 1'b0, 1'b1);
    run_instr(T_BEQ, 3'b000, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++)
      run_instr(legal_ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // sw interrupted by reset in MEMADR, then a jal from a clean start.
    drive(T_SW, 3'b010, 1'b0, 1'b0);
    expect_instr(T_SW, 3'b010, 1'b0, 1'b0, 3, n);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    reset_into(T_JAL, 3'b000, 1'b0, 1'b0);

    run_instr(T_R, 3'b110, 1'b0, 1'b1);
    run_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
    reset_into(T_LW, 3'b000, 1'b0, 1'b0);
    run_instr(T_I, 3'b111, 1'b0, 1'b0);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 50) begin
      @(posedge clk);
      wait_cyc++;
    end
    #6;
    n_checks++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual %0d cycles/%0d retirements outstanding required 0/0",
               exp_q.size(), done_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
